pwm_generator: RTL and testbench



---
 rtl/pwm_pkg.sv | 10 +
 rtl/clk_divider.sv | 43 ++++
 rtl/pwm_generator.sv | 79 +++++++
 tb/tb_pwm_generator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM source and its slow square-wave divider.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int PW_WIDTH_DEF = 4;
  localparam int DIV_HALF_DEF = 1000;

  typedef logic [PW_WIDTH_DEF-1:0] pw_t;

endpackage

// File: rtl/clk_divider.sv
// Free-running divider: toggles clk_out every DIV_HALF cycles of clk_1MHz.
// clk_out is a registered data signal, never a clock for anything inside this block.
`timescale 1ns/1ps
module clk_divider
  import pwm_pkg::*;
#(
  parameter int DIV_HALF = DIV_HALF_DEF
) (
  input  logic clk_1MHz,
  input  logic rst,
  output logic clk_out
);

  localparam int            CW   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          tog_q, tog_d;

  // Count 0..DIV_HALF-1; on the last count wrap to 0 and flip the output.
  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    tog_d     = tog_q;
    if (div_cnt_q == LAST) begin
      div_cnt_d = '0;
      tog_d     = ~tog_q;
    end
  end

  // Divider state register with synchronous reset.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      div_cnt_q <= '0;
      tog_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tog_q     <= tog_d;
    end
  end

  assign clk_out = tog_q;

endmodule

// File: rtl/pwm_generator.sv
// Fixed-period PWM source (period 2^PW_WIDTH cycles) plus a 500 Hz square wave.
// Optional feature macro: PWM_SYNC_UPDATE_EN -- when defined, the duty word is
// latched into a shadow register at the last cycle of each period so changes
// only take effect on a period boundary.
// There is no handshake: pulse_width is sampled every cycle and is expected to
// be stable or synchronous to clk_1MHz.
`timescale 1ns/1ps
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int PW_WIDTH = PW_WIDTH_DEF,
  parameter int DIV_HALF = DIV_HALF_DEF
) (
  input  logic                clk_1MHz,
  input  logic                rst,
  input  logic [PW_WIDTH-1:0] pulse_width,
  output logic                clk_500Hz,
  output logic                pwm_signal
);

  logic [PW_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PW_WIDTH-1:0] duty;
  logic                pwm_q, pwm_d;

  clk_divider #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_divider (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .clk_out  (clk_500Hz)
  );

`ifdef PWM_SYNC_UPDATE_EN
  localparam logic [PW_WIDTH-1:0] PW_LAST = '1;

  logic [PW_WIDTH-1:0] pw_active_q, pw_active_d;

  // Shadow the duty word only on the final cycle of a period.
  always_comb begin
    pw_active_d = pw_active_q;
    if (pwm_cnt_q == PW_LAST) begin
      pw_active_d = pulse_width;
    end
  end

  // Shadow duty register with synchronous reset.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      pw_active_q <= '0;
    end else begin
      pw_active_q <= pw_active_d;
    end
  end

  assign duty = pw_active_q;
`else
  assign duty = pulse_width;
`endif

  // Period counter wraps naturally; output is the registered unsigned compare.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PW_WIDTH'(1);
    pwm_d     = (pwm_cnt_q < duty);
  end

  // PWM counter and output register with synchronous reset.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_signal = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed sequence with randomized duty segments,
// compared cycle by cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int PW_WIDTH = PW_WIDTH_DEF;
  localparam int DIV_HALF = DIV_HALF_DEF;
  localparam int PERIOD   = 1 << PW_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk_1MHz = 1'b0;
  logic rst;
  pw_t  pulse_width;
  logic clk_500Hz;
  logic pwm_signal;

  always #500 clk_1MHz = ~clk_1MHz;

  pwm_generator #(
    .PW_WIDTH (PW_WIDTH),
    .DIV_HALF (DIV_HALF)
  ) dut (
    .clk_1MHz    (clk_1MHz),
    .rst         (rst),
    .pulse_width (pulse_width),
    .clk_500Hz   (clk_500Hz),
    .pwm_signal  (pwm_signal)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          n_edge = 0;       // edges since reset release
  int          pw_hist[$];       // pulse_width seen at edge k stored at index k-1
  int          high_cnt = 0;
  int          clk_high_cnt = 0;
  logic        prev_clk = 1'b0;
  int          clk_edges[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n_edge);
    end
  endtask

  // Reference model: value of pwm_signal right after edge n (n >= 1).
  // Position in the period is (n-1) mod PERIOD; the output is high while that
  // position is below the duty governing this period.
  function automatic int model_pwm(input int n);
    int pos;
    int duty;
    pos = (n - 1) % PERIOD;
`ifdef PWM_SYNC_UPDATE_EN
    begin
      int cap;
      cap  = n - pos - 1;  // edge that closed the previous period
      duty = (cap >= 1) ? pw_hist[cap-1] : 0;
    end
`else
    duty = pw_hist[n-1];
`endif
    return (pos < duty) ? 1 : 0;
  endfunction

  // Square wave is high during every odd block of DIV_HALF edges.
  function automatic int model_clk(input int n);
    return (n / DIV_HALF) % 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_1MHz);
    #1;
    if (rst) begin
      check("rst_pwm", 32'(pwm_signal), 32'd0);
      check("rst_clk500", 32'(clk_500Hz), 32'd0);
      n_edge   = 0;
      pw_hist.delete();
      prev_clk = 1'b0;
    end else begin
      n_edge++;
      pw_hist.push_back(int'(pulse_width));
      check("pwm", 32'(pwm_signal), 32'(model_pwm(n_edge)));
      check("clk500", 32'(clk_500Hz), 32'(model_clk(n_edge)));
      if (pwm_signal === 1'b1) high_cnt++;
      if (clk_500Hz !== prev_clk) clk_edges.push_back(n_edge);
      if (n_edge >= DIV_HALF && n_edge < 5 * DIV_HALF && clk_500Hz === 1'b1) clk_high_cnt++;
      prev_clk = clk_500Hz;
    end
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  // Count pwm high cycles over one whole period (call on a period boundary).
  task automatic count_period(input string tag, input int exp_high);
    high_cnt = 0;
    run(PERIOD);
    check(tag, 32'(high_cnt), 32'(exp_high));
  endtask

  task automatic hold_duty(input string tag, input int pw);
    pulse_width = pw_t'(pw);
    run(PERIOD);                 // transition period
    count_period(tag, pw);
    run(PERIOD);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst         = 1'b1;
    pulse_width = pw_t'(5);
    run(3);
    rst = 1'b0;

    // first periods after release; per-edge model covers edges 1..5 high
    run(PERIOD);
    count_period("duty5_period", 5);

    // duty 0: never high
    pulse_width = pw_t'(0);
    run(PERIOD);
    high_cnt = 0;
    run(4 * PERIOD);
    check("duty0_64cyc", 32'(high_cnt), 32'd0);

    hold_duty("duty2_period", 2);
    hold_duty("duty8_period", 8);
    hold_duty("duty14_period", 14);
    hold_duty("duty15_period", 15);

    // randomized duty segments of random length
    for (int seg = 0; seg < 12; seg++) begin
      pulse_width = pw_t'($urandom_range(0, PERIOD - 1));
      run($urandom_range(1, 40));
    end

    // mid-period reset at pwm_cnt = 7, duty 12, with clk_500Hz high
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    pulse_width = pw_t'(12);
    run(63 * PERIOD + 7);
    check("pre_rst_clk500_high", 32'(clk_500Hz), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // free run after restart: divider phase and 50% duty
    clk_edges.delete();
    clk_high_cnt = 0;
    run(5 * DIV_HALF);
    for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i * DIV_HALF));
    check("clk500_edge_count", 32'(clk_edges.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < clk_edges.size(); i++) begin
      check("clk500_edge_pos", 32'(clk_edges[i]), exp_q[i]);
    end
    check("clk500_duty50", 32'(clk_high_cnt), 32'(2 * DIV_HALF));

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
